// File: rtl/muldiv_hilo_unit_if.sv
// Bus between the EX stage and the iterative multiply/divide unit with its HI/LO pair.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO registers.
// Define MULDIV_SIGNED_EN to honour op[0] as signed; otherwise every operation is unsigned.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                Reset,
    muldiv_hilo_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dbz_pend;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_signed;
    logic             sa;
    logic             sb;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

`ifdef MULDIV_SIGNED_EN
    assign is_signed = bus.op[0];
`else
    assign is_signed = 1'b0;
`endif

    assign sa     = is_signed & bus.src_a[WIDTH-1];
    assign sb     = is_signed & bus.src_b[WIDTH-1];
    assign b_zero = (bus.src_b == '0);
    assign abs_a  = sa ? -bus.src_a : bus.src_a;
    assign abs_b  = sb ? -bus.src_b : bus.src_b;

    // State register.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a divide by zero skips RUN entirely.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.op[1] && b_zero) ? FIX : RUN;
            RUN:     if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.busy        = (state != IDLE);
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
    end

    // One iteration step: acc:mq shifts right for multiply, left for divide.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] mq_step;

    always_comb begin
        add_sum  = acc + {1'b0, opnd};
        shifted  = {acc[WIDTH-1:0], mq[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, opnd};
        acc_step = acc;
        mq_step  = mq;
        if (is_div) begin
            if (!trial[WIDTH+1]) begin
                acc_step = trial[WIDTH:0];
                mq_step  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = shifted;
                mq_step  = {mq[WIDTH-2:0], 1'b0};
            end
        end else if (mq[0]) begin
            acc_step = {1'b0, add_sum[WIDTH:1]};
            mq_step  = {add_sum[0], mq[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[WIDTH:1]};
            mq_step  = {acc[0], mq[WIDTH-1:1]};
        end
    end

    // Sign-corrected results applied in FIX.
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_raw = {acc[WIDTH-1:0], mq};
        prod_fix = neg_lo ? -prod_raw : prod_raw;
        quo_fix  = neg_lo ? -mq : mq;
        rem_fix  = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Datapath and HI/LO ownership.
    // NOTE: every datapath register is reset so an aborted operation leaves no residue.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dbz_pend <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        is_div <= bus.op[1];
                        dbz_q  <= 1'b0;
                        if (bus.op[1] && b_zero) begin
                            // Preload the fixed divide-by-zero result; FIX then passes it through.
                            acc      <= {1'b0, bus.src_a};
                            mq       <= '1;
                            opnd     <= '0;
                            neg_lo   <= 1'b0;
                            neg_hi   <= 1'b0;
                            dbz_pend <= 1'b1;
                        end else begin
                            acc      <= '0;
                            mq       <= abs_a;
                            opnd     <= abs_b;
                            neg_lo   <= sa ^ sb;
                            neg_hi   <= bus.op[1] ? sa : (sa ^ sb);
                            dbz_pend <= 1'b0;
                        end
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    mq  <= mq_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    dbz_q <= dbz_pend;
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences and random operations against an arithmetic model.
module tb_muldiv_hilo_unit;
    localparam int W = 32;

    logic clk;
    logic Reset;
    int   n_cmp;
    int   n_fail;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        logic            sgn;
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
`ifdef MULDIV_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        z  = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!op[1]) begin
            if (sgn) begin
                sp = sa * sb;
                {h, l} = sp;
            end else begin
                up = ua * ub;
                {h, l} = up;
            end
        end else if (b == 0) begin
            l = '1;
            h = a;
            z = 1'b1;
        end else if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            l  = sq[W-1:0];
            h  = sr[W-1:0];
        end else begin
            up = ua / ub;
            l  = up[W-1:0];
            up = ua % ub;
            h  = up[W-1:0];
        end
    endfunction

    // Issue one operation and wait for done; lat counts edges after the accept edge.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        check("dbz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
        bcnt = bus.busy ? 1 : 0;
        lat  = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done && bus.busy) bcnt++;
        end
        if (!bus.done) check("done_timeout", 64'(lat), 64'd0);
        check("busy_low_at_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int           lat;
        int           bcnt;
        int           seen;
        logic [W-1:0] eh, el, lo_prev;
        logic         ez;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        n_cmp  = 0;
        n_fail = 0;
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
        Reset = 1'b1;

        vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33};
        vecs[1] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
        vecs[2] = '{2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[5] = '{2'b10, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33};
`ifdef MULDIV_SIGNED_EN
        vecs[6] = '{2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
        vecs[7] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[8] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33};
`else
        vecs[6] = '{2'b01, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, 33};
        vecs[7] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 33};
        vecs[8] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        Reset = 1'b0;

        // Directed vector table, with an idle cycle after each to confirm done is a pulse.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end

        // A second start mid-operation is ignored.
        model(2'b11, 32'hFFFF_FFF9, 32'd2, eh, el, ez);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'hFFFF_FFF9; bus.src_b = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ignored_start_latency", 64'(lat), 64'd33);
        check("ignored_start_hi", 64'(bus.hi), 64'(eh));
        check("ignored_start_lo", 64'(bus.lo), 64'(el));
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check("ignored_start_no_second_op", 64'(seen), 64'd0);

        // MTHI/MTLO in idle, writes dropped while busy, then reset mid-RUN.
        lo_prev = bus.lo;
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_lo_untouched", 64'(bus.lo), 64'(lo_prev));
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hABCD;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("mthi_mtlo_hi", 64'(bus.hi), 64'hABCD);
        check("mthi_mtlo_lo", 64'(bus.lo), 64'hABCD);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'd6;
        bus.wr_lo = 1'b1; bus.wr_data = 32'h9999;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.wr_lo = 1'b0;
        check("mtlo_at_accept_dropped", 64'(bus.lo), 64'hABCD);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.wr_lo = 1'b1; bus.wr_data = 32'h5555;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        check("mtlo_while_busy_dropped", 64'(bus.lo), 64'hABCD);
        check("hi_stale_while_busy", 64'(bus.hi), 64'hABCD);
        repeat (5) @(posedge clk);
        #1;
        Reset = 1'b1;
        #1;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        Reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Random back-to-back operations; each start lands in the previous done cycle.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = {28'hFFFF_FFF, 4'($urandom)};
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eh, el, ez);
            do_op(rop, ra, rb, lat, bcnt);
            check($sformatf("rnd%0d_latency", i), 64'(lat), (rop[1] && rb == 0) ? 64'd1 : 64'd33);
            check($sformatf("rnd%0d_hi", i), 64'(bus.hi), 64'(eh));
            check($sformatf("rnd%0d_lo", i), 64'(bus.lo), 64'(el));
            check($sformatf("rnd%0d_dbz", i), 64'(bus.div_by_zero), 64'(ez));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
